// File: rtl/gam_pattern_feeder.sv
// gam_pattern_feeder
// Stores a CLASS_COUNT x NODE_COUNT table of 128-bit training patterns and,
// on start, presents every valid entry on x for DWELL cycles each, in
// class-major/node-minor order, tagging it with its 1-based class number c.
//
// Optional feature: define GAM_FEEDER_RECALL_EN to add a recall replay after
// the learning pass. The replay counts entries whose recalling_pattern
// matches x on the last hold cycle.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   wr_en/wr_class/wr_node/wr_data
//                      pattern-table write, accepted only when idle
//   start              one-cycle request to begin a pass, accepted only when idle
//   recalling_pattern  (recall build only) pattern returned by recall logic
//   match_count        (recall build only) number of recall matches this pass
//   x, c               presented pattern and its class number (1-based)
//   learning_done      0 while learning patterns are being presented
//   learning_recall    phase indicator, 0 = LEARNING, 1 = RECALL
//   busy               high whenever the feeder is not idle
//   done               one-cycle pulse at the end of a pass
module gam_pattern_feeder #(
    parameter int unsigned CLASS_COUNT = 4,
    parameter int unsigned NODE_COUNT  = 5,
    parameter int unsigned DWELL       = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [$clog2(CLASS_COUNT)-1:0] wr_class,
    input  logic [$clog2(NODE_COUNT)-1:0]  wr_node,
    input  logic [127:0]                   wr_data,
    input  logic                           start,
`ifdef GAM_FEEDER_RECALL_EN
    input  logic [127:0]                   recalling_pattern,
    output logic [15:0]                    match_count,
`endif
    output logic [127:0]                   x,
    output logic [31:0]                    c,
    output logic                           learning_done,
    output logic                           learning_recall,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned CW      = $clog2(CLASS_COUNT);
    localparam int unsigned NW      = $clog2(NODE_COUNT);
    localparam int unsigned ENTRIES = CLASS_COUNT * NODE_COUNT;
    localparam int unsigned IW      = $clog2(ENTRIES);
    localparam int unsigned VW      = 128;
    localparam int unsigned DW      = 8;

    localparam logic LEARNING = 1'b0;
`ifdef GAM_FEEDER_RECALL_EN
    localparam logic RECALL   = 1'b1;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        HOLD   = 3'd2,
        FINISH = 3'd3
`ifdef GAM_FEEDER_RECALL_EN
        ,
        RFETCH = 3'd4,
        RHOLD  = 3'd5
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cls_q, cls_d;
    logic [NW-1:0]   node_q, node_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [VW-1:0]   x_q, x_d;
    logic [31:0]     c_q, c_d;
    logic            ld_q, ld_d;
    logic            lr_q, lr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef GAM_FEEDER_RECALL_EN
    logic [15:0]     mc_q, mc_d;
`endif

    logic [VW-1:0]      mem [ENTRIES];
    logic [ENTRIES-1:0] valid_q;

    logic [IW-1:0]   rd_idx;
    logic [IW-1:0]   wr_idx;
    logic            wr_ok;
    logic            last_entry;
    logic            hold_last;
    logic [CW-1:0]   cls_adv;
    logic [NW-1:0]   node_adv;

    // Table addressing and scan-pointer arithmetic
    always_comb begin
        rd_idx     = IW'(32'(cls_q) * NODE_COUNT + 32'(node_q));
        wr_idx     = IW'(32'(wr_class) * NODE_COUNT + 32'(wr_node));
        wr_ok      = wr_en && (state_q == IDLE) &&
                     (32'(wr_class) < CLASS_COUNT) && (32'(wr_node) < NODE_COUNT);
        last_entry = (cls_q == CW'(CLASS_COUNT - 1)) && (node_q == NW'(NODE_COUNT - 1));
        hold_last  = (cnt_q == DW'(DWELL - 1));
        if (node_q == NW'(NODE_COUNT - 1)) begin
            node_adv = '0;
            cls_adv  = cls_q + CW'(1);
        end else begin
            node_adv = node_q + NW'(1);
            cls_adv  = cls_q;
        end
    end

    // Pattern table; valid bits are cleared by reset, data is not
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_ok) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        node_d  = node_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        c_d     = c_q;
        ld_d    = ld_q;
        lr_d    = lr_q;
`ifdef GAM_FEEDER_RECALL_EN
        mc_d    = mc_q;
`endif
        case (state_q)
            IDLE: begin
                lr_d = LEARNING;
                if (start) begin
                    state_d = FETCH;
                    cls_d   = '0;
                    node_d  = '0;
`ifdef GAM_FEEDER_RECALL_EN
                    mc_d    = '0;
`endif
                end
            end
            FETCH: begin
                if (valid_q[rd_idx]) begin
                    x_d     = mem[rd_idx];
                    c_d     = 32'(cls_q) + 32'd1;
                    ld_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else if (last_entry) begin
`ifdef GAM_FEEDER_RECALL_EN
                    state_d = RFETCH;
                    cls_d   = '0;
                    node_d  = '0;
                    lr_d    = RECALL;
`else
                    state_d = FINISH;
`endif
                    ld_d    = 1'b1;
                end else begin
                    cls_d   = cls_adv;
                    node_d  = node_adv;
                end
            end
            HOLD: begin
                if (hold_last) begin
                    if (last_entry) begin
`ifdef GAM_FEEDER_RECALL_EN
                        state_d = RFETCH;
                        cls_d   = '0;
                        node_d  = '0;
                        lr_d    = RECALL;
`else
                        state_d = FINISH;
`endif
                        ld_d    = 1'b1;
                    end else begin
                        state_d = FETCH;
                        cls_d   = cls_adv;
                        node_d  = node_adv;
                    end
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
`ifdef GAM_FEEDER_RECALL_EN
            RFETCH: begin
                if (valid_q[rd_idx]) begin
                    x_d     = mem[rd_idx];
                    c_d     = 32'(cls_q) + 32'd1;
                    cnt_d   = '0;
                    state_d = RHOLD;
                end else if (last_entry) begin
                    state_d = FINISH;
                end else begin
                    cls_d   = cls_adv;
                    node_d  = node_adv;
                end
            end
            RHOLD: begin
                if (hold_last) begin
                    // Recall result is judged on the final cycle of the dwell
                    if (recalling_pattern == x_q) begin
                        mc_d = mc_q + 16'd1;
                    end
                    if (last_entry) begin
                        state_d = FINISH;
                    end else begin
                        state_d = RFETCH;
                        cls_d   = cls_adv;
                        node_d  = node_adv;
                    end
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
`endif
            FINISH: begin
                state_d = IDLE;
                ld_d    = 1'b1;
                lr_d    = LEARNING;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cls_q   <= '0;
            node_q  <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            c_q     <= '0;
            ld_q    <= 1'b1;
            lr_q    <= LEARNING;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef GAM_FEEDER_RECALL_EN
            mc_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            node_q  <= node_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            c_q     <= c_d;
            ld_q    <= ld_d;
            lr_q    <= lr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef GAM_FEEDER_RECALL_EN
            mc_q    <= mc_d;
`endif
        end
    end

    assign x               = x_q;
    assign c               = c_q;
    assign learning_done   = ld_q;
    assign learning_recall = lr_q;
    assign busy            = busy_q;
    assign done            = done_q;
`ifdef GAM_FEEDER_RECALL_EN
    assign match_count     = mc_q;
`endif

endmodule

// File: tb/tb_gam_pattern_feeder.sv
// Testbench for gam_pattern_feeder (default build, recall feature disabled).
// Expected presentations are queued when start is driven and retired as the
// DUT shows them; pass lengths come from a table of hand-computed values.
module tb_gam_pattern_feeder;

    localparam int unsigned CLASS_COUNT = 4;
    localparam int unsigned NODE_COUNT  = 5;
    localparam int unsigned DWELL       = 10;
    localparam int unsigned ENTRIES     = CLASS_COUNT * NODE_COUNT;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [1:0]   wr_class;
    logic [2:0]   wr_node;
    logic [127:0] wr_data;
    logic         start;
    logic [127:0] x;
    logic [31:0]  c;
    logic         learning_done;
    logic         learning_recall;
    logic         busy;
    logic         done;
`ifdef GAM_FEEDER_RECALL_EN
    logic [127:0] recalling_pattern;
    logic [15:0]  match_count;
    assign recalling_pattern = x;
`endif

    gam_pattern_feeder #(
        .CLASS_COUNT(CLASS_COUNT),
        .NODE_COUNT (NODE_COUNT),
        .DWELL      (DWELL)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_en            (wr_en),
        .wr_class         (wr_class),
        .wr_node          (wr_node),
        .wr_data          (wr_data),
        .start            (start),
`ifdef GAM_FEEDER_RECALL_EN
        .recalling_pattern(recalling_pattern),
        .match_count      (match_count),
`endif
        .x                (x),
        .c                (c),
        .learning_done    (learning_done),
        .learning_recall  (learning_recall),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned  t0;
        logic [127:0] x;
        logic [31:0]  c;
    } pres_t;

    typedef struct {
        logic [19:0] mask;
        int unsigned exp_done;
    } vec_t;

    pres_t        sb[$];
    logic         mdl_valid [ENTRIES];
    logic [127:0] mdl_data  [ENTRIES];
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        wr_en = 1'b0;
        start = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        for (int i = 0; i < int'(ENTRIES); i++) mdl_valid[i] = 1'b0;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_learning_done", 128'(learning_done), 128'(1));
        chk("rst_learning_recall", 128'(learning_recall), 128'(0));
        chk("rst_x", x, 128'(0));
        chk("rst_c", 128'(c), 128'(0));
    endtask

    task automatic wr(input int unsigned idx, input logic [127:0] d);
        wr_en    = 1'b1;
        wr_class = 2'(idx / NODE_COUNT);
        wr_node  = 3'(idx % NODE_COUNT);
        wr_data  = d;
        tick;
        wr_en    = 1'b0;
        mdl_valid[idx] = 1'b1;
        mdl_data[idx]  = d;
    endtask

    // Runs one learning pass; inj > 0 drives wr_en+start during that cycle
    task automatic run_pass(input int unsigned inj, output int unsigned done_at);
        int unsigned  t;
        int unsigned  first_x;
        logic         any;
        logic [127:0] last_x;
        logic [31:0]  last_c;
        pres_t        p;
        t       = 1;
        first_x = 0;
        any     = 1'b0;
        last_x  = x;
        last_c  = c;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (mdl_valid[i]) begin
                p.t0 = t + 1;
                p.x  = mdl_data[i];
                p.c  = 32'(i / int'(NODE_COUNT) + 1);
                sb.push_back(p);
                if (!any) first_x = t + 1;
                any    = 1'b1;
                last_x = p.x;
                last_c = p.c;
                t      = t + 1 + DWELL;
            end else begin
                t = t + 1;
            end
        end
        done_at = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int unsigned n = 1; n <= t + 1; n++) begin
            if (done === 1'b1 && done_at == 0) done_at = n;
            chk("done", 128'(done), 128'(n == t));
            chk("busy", 128'(busy), 128'(n <= t));
            chk("learning_done", 128'(learning_done), 128'(!(any && n >= first_x && n < t)));
            chk("learning_recall", 128'(learning_recall), 128'(0));
            if (sb.size() > 0 && n >= sb[0].t0) begin
                chk("x", x, sb[0].x);
                chk("c", 128'(c), 128'(sb[0].c));
                if (n == sb[0].t0 + DWELL - 1) void'(sb.pop_front());
            end
            if (n == inj) begin
                wr_en    = 1'b1;
                wr_class = 2'd0;
                wr_node  = 3'd3;
                wr_data  = 128'd99;
                start    = 1'b1;
            end else begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            if (n <= t) tick;
        end
        chk("x_retained", x, last_x);
        chk("c_retained", 128'(c), 128'(last_c));
        chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        vec_t        vecs [6];
        int unsigned d_at;
        int          pulses;

        vecs[0] = '{20'h00000, 21};
        vecs[1] = '{20'h00007, 51};
        vecs[2] = '{20'h80000, 31};
        vecs[3] = '{20'h00001, 31};
        vecs[4] = '{20'h10421, 61};
        vecs[5] = '{20'hFFFFF, 221};

        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_class = '0;
        wr_node  = '0;
        wr_data  = '0;
        start    = 1'b0;

        // Table-driven passes over different valid-entry patterns
        for (int v = 0; v < 6; v++) begin
            logic [19:0] m;
            do_reset;
            m = vecs[v].mask;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                if (m[i]) wr(i, {32'(i), 32'hA5A50000 ^ 32'(i), $urandom(), $urandom()});
            end
            run_pass(0, d_at);
            chk("done_latency", 128'(d_at), 128'(vecs[v].exp_done));
        end

        // Three patterns in class 0
        do_reset;
        wr(0, 128'd1234);
        wr(1, 128'd22313);
        wr(2, 128'd324234);
        run_pass(0, d_at);
        chk("seq_done_latency", 128'(d_at), 128'(51));
        chk("seq_last_x", x, 128'd324234);
        chk("seq_c", 128'(c), 128'(1));

        // wr_en and start during HOLD are ignored
        run_pass(3, d_at);
        chk("busy_inj_done_latency", 128'(d_at), 128'(51));
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("no_restart_busy", 128'(busy), 128'(0));
        end
        run_pass(0, d_at);
        chk("no_table_change_latency", 128'(d_at), 128'(51));

        // Reset in the second HOLD cycle aborts the pass
        do_reset;
        wr(0, 128'hDEAD_BEEF);
        wr(7, 128'h1111_2222);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        chk("abort_hold_x", x, 128'hDEAD_BEEF);
        chk("abort_hold_ld", 128'(learning_done), 128'(0));
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int i = 0; i < int'(ENTRIES); i++) mdl_valid[i] = 1'b0;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_ld", 128'(learning_done), 128'(1));
        chk("abort_x", x, 128'(0));
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1) pulses++;
            tick;
        end
        chk("abort_no_done", 128'(pulses), 128'(0));
        run_pass(0, d_at);
        chk("abort_table_cleared", 128'(d_at), 128'(21));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gam_pattern_feeder.md
GAM_PATTERN_FEEDER -- requirements
Module: gam_pattern_feeder

Interface
REQ-001 SHALL have parameter CLASS_COUNT, default 4, number of pattern classes stored.
REQ-002 SHALL have parameter NODE_COUNT, default 5, patterns per class.
REQ-003 SHALL have parameter DWELL, default 10, cycles each pattern is held on x (legal range 1..255).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  pattern-table write strobe.
REQ-007 SHALL have port wr_class  input  $clog2(CLASS_COUNT)  class index of write.
REQ-008 SHALL have port wr_node  input  $clog2(NODE_COUNT)  node index of write.
REQ-009 SHALL have port wr_data  input  node_vector_T (128)  pattern to store.
REQ-010 SHALL have port start  input  1  one-cycle request to begin a learning pass.
REQ-011 SHALL have port x  output  node_vector_T (128)  pattern driven to Memory_Layer.
REQ-012 SHALL have port c  output  int (32)  class number of x, 1-based.
REQ-013 SHALL have port learning_done  output  1  0 while patterns are being presented.
REQ-014 SHALL have port learning_recall  output  LEARNING_RECALL_T  phase indicator to Memory_Layer and recall.
REQ-015 SHALL have port busy  output  1  high outside IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of pass.

Function
REQ-017 SHALL hold a CLASS_COUNT x NODE_COUNT table of 128-bit patterns, each with a valid bit; wr_en in IDLE writes wr_data and sets valid next cycle.
REQ-018 SHALL ignore wr_en and start while busy=1.
REQ-019 SHALL implement states IDLE, FETCH, HOLD, FINISH (plus RECALL states under REQ-031).
REQ-020 IDLE: start=1 -> FETCH with scan pointer at class 0, node 0; busy=1 from next cycle.
REQ-021 FETCH: examines one entry per cycle; valid -> load x, c=class+1, learning_done=0, go HOLD; invalid -> advance pointer, stay FETCH.
REQ-022 HOLD: keeps x and c stable exactly DWELL cycles, then advances pointer and returns to FETCH.
REQ-023 Scan order: node increments first, wrapping to 0 with class increment; after entry (CLASS_COUNT-1, NODE_COUNT-1) -> FINISH.
REQ-024 FINISH: learning_done=1, done=1 for one cycle, -> IDLE; x and c retain last presented values.
REQ-025 With no valid entries, start SHALL produce done exactly CLASS_COUNT*NODE_COUNT+1 cycles later, learning_done never deasserting.
REQ-026 Per valid pattern, x SHALL be stable DWELL cycles; first x update one cycle after the FETCH cycle finding it.
REQ-027 learning_recall SHALL equal LEARNING throughout learning pass and IDLE.

Reset
REQ-028 reset=1 SHALL force IDLE and clear all valid bits, busy=0, done=0, learning_done=1, learning_recall=LEARNING, x=0, c=0.
REQ-029 reset mid-pass SHALL abort without a done pulse; table contents need not be preserved.
REQ-030 reset SHALL take priority over start and wr_en in the same cycle.

Configuration
REQ-031 Macro GAM_FEEDER_RECALL_EN defined: after learning pass, SHALL replay every valid entry in same order/DWELL with learning_recall=RECALL, learning_done=1, and add input recalling_pattern (128) and output match_count (16), counting entries where recalling_pattern equals x on the last HOLD cycle; done then pulses after replay; match_count clears on start.
REQ-032 Macro undefined: no RECALL states, recalling_pattern and match_count ports absent, learning_recall constant LEARNING.

Verification
REQ-033 Reset, then observe outputs -> busy=0, done=0, learning_done=1, x=0, c=0.
REQ-034 Write (0,0)=1234, (0,1)=22313, (0,2)=324234, DWELL=10, start -> x=1234/22313/324234 each 10 cycles, c=1, learning_done=0, done pulse after final entry scan.
REQ-035 Empty table, start -> done exactly 21 cycles after start (defaults), learning_done stays 1.
REQ-036 wr_en and start asserted during HOLD -> no table change, pass unaffected, no restart.
REQ-037 reset asserted in second HOLD cycle -> IDLE next cycle, no done pulse, learning_done=1.
REQ-038 With GAM_FEEDER_RECALL_EN, recalling_pattern looped from x for 2 of 3 entries -> match_count=2 at done.
